// File: rtl/reset_pulse_meter_pkg.sv
// Shared definitions for the reset pulse generator/meter pair.
//   meter_state_e : states of the pulse measurement FSM
//   ns_to_cycles  : converts a duration in ns to clock cycles, rounding up
package reset_pulse_pkg;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        MEASURE  = 2'd2
    } meter_state_e;

    // Rounds up so that a generated or checked pulse is never shorter than requested.
    function automatic longint unsigned ns_to_cycles(input longint unsigned clock_hz,
                                                     input longint unsigned ns);
        return (ns * clock_hz + 64'd999_999_999) / 64'd1_000_000_000;
    endfunction

endpackage

// File: rtl/reset_pulse_meter_if.sv
// Signal bundle between a pulse source/observer and reset_pulse_meter.
//   pulse_in    : asynchronous active-high pulse to measure
//   clear_flags : synchronous clear of reset_seen
//   width_out   : width of the last completed pulse (cycles, saturating)
//   width_valid : one-cycle strobe marking a completed pulse
//   too_short   : last pulse below the qualification width
//   saturated   : last pulse reached the counter maximum
//   reset_seen  : sticky, set by any qualified pulse
//   pulse_count : number of qualified pulses, modulo 256
// COUNT_W must match the COUNT_W of the attached meter.
interface reset_pulse_meter_if #(
    parameter int COUNT_W = 8
);
    logic               pulse_in;
    logic               clear_flags;
    logic [COUNT_W-1:0] width_out;
    logic               width_valid;
    logic               too_short;
    logic               saturated;
    logic               reset_seen;
    logic [7:0]         pulse_count;

    modport master (
        output pulse_in,
        output clear_flags,
        input  width_out,
        input  width_valid,
        input  too_short,
        input  saturated,
        input  reset_seen,
        input  pulse_count
    );

    modport slave (
        input  pulse_in,
        input  clear_flags,
        output width_out,
        output width_valid,
        output too_short,
        output saturated,
        output reset_seen,
        output pulse_count
    );
endinterface

// File: rtl/reset_pulse_meter_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output, two edges behind d
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/reset_pulse_meter.sv
// Measures the high width of an asynchronous pulse in clock cycles and
// classifies each completed pulse as qualified, too short or saturated.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of reset_pulse_meter_if (pulse_in, clear_flags in;
//           width_out, width_valid, too_short, saturated, reset_seen,
//           pulse_count out, all registered)
module reset_pulse_meter
    import reset_pulse_pkg::*;
#(
    parameter int CLOCK_HZ = 48000000,
    parameter int MIN_NS   = 255,
    parameter int COUNT_W  = 8
) (
    input  logic clk,
    input  logic rst_n,
    reset_pulse_meter_if.slave bus
);
    localparam longint unsigned MIN_CYCLES_L = ns_to_cycles(64'(CLOCK_HZ), 64'(MIN_NS));
    localparam longint unsigned CNT_MAX_L    = (64'd1 << COUNT_W) - 64'd1;

    if ((MIN_CYCLES_L == 64'd0) || (MIN_CYCLES_L > CNT_MAX_L)) begin : g_min_cycles_bad
        $error("reset_pulse_meter: MIN_CYCLES must be in 1..2**COUNT_W-1");
    end

    localparam logic [COUNT_W-1:0] MIN_CYCLES = COUNT_W'(MIN_CYCLES_L);
    localparam logic [COUNT_W-1:0] CNT_MAX    = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] CNT_ONE    = COUNT_W'(1'b1);

    logic               sync_q_s;
    logic [1:0]         settle_r;
    logic               ready_s;
    meter_state_e       state_r, state_s;
    logic [COUNT_W-1:0] cnt_r, cnt_s;
    logic [COUNT_W-1:0] width_r, width_s;
    logic               valid_r, valid_s;
    logic               short_r, short_s;
    logic               sat_r, sat_s;
    logic               seen_r, seen_s;
    logic [7:0]         count_r, count_s;
    logic               qual_s;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.pulse_in),
        .q     (sync_q_s)
    );

    // Tracks when sync_q reflects a real sample rather than the flops' reset zeros;
    // without it a pulse already high at reset release would look like a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_r <= 2'b00;
        end else begin
            settle_r <= {settle_r[0], 1'b1};
        end
    end

    assign ready_s = settle_r[1];

    // Next-state, counter and result logic of the measurement FSM.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        width_s = width_r;
        valid_s = 1'b0;
        short_s = short_r;
        sat_s   = sat_r;
        qual_s  = 1'b0;
        case (state_r)
            WAIT_LOW: begin
                if (ready_s && !sync_q_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_LOW;
                end
            end
            IDLE: begin
                if (sync_q_s) begin
                    state_s = MEASURE;
                    cnt_s   = CNT_ONE;
                end else begin
                    state_s = IDLE;
                end
            end
            MEASURE: begin
                if (sync_q_s) begin
                    // Hold at the maximum so long pulses read as saturated, not wrapped.
                    if (cnt_r == CNT_MAX) begin
                        cnt_s = cnt_r;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    width_s = cnt_r;
                    valid_s = 1'b1;
                    short_s = (cnt_r < MIN_CYCLES);
                    sat_s   = (cnt_r == CNT_MAX);
                    qual_s  = !(cnt_r < MIN_CYCLES);
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = WAIT_LOW;
            end
        endcase

        // A qualified strobe beats a coincident clear so no pulse goes unnoticed.
        if (qual_s) begin
            seen_s = 1'b1;
        end else if (bus.clear_flags) begin
            seen_s = 1'b0;
        end else begin
            seen_s = seen_r;
        end

        if (qual_s) begin
            count_s = count_r + 8'd1;
        end else begin
            count_s = count_r;
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= WAIT_LOW;
            cnt_r   <= {COUNT_W{1'b0}};
            width_r <= {COUNT_W{1'b0}};
            valid_r <= 1'b0;
            short_r <= 1'b0;
            sat_r   <= 1'b0;
            seen_r  <= 1'b0;
            count_r <= 8'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            width_r <= width_s;
            valid_r <= valid_s;
            short_r <= short_s;
            sat_r   <= sat_s;
            seen_r  <= seen_s;
            count_r <= count_s;
        end
    end

    assign bus.width_out   = width_r;
    assign bus.width_valid = valid_r;
    assign bus.too_short   = short_r;
    assign bus.saturated   = sat_r;
    assign bus.reset_seen  = seen_r;
    assign bus.pulse_count = count_r;
endmodule

// File: tb/tb_reset_pulse_meter.sv
module tb_reset_pulse_meter;

    typedef struct {
        int width;
        bit ts;
        bit sat;
        int cnt;
        bit seen;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    reset_pulse_meter_if #(.COUNT_W(8)) bus ();

    reset_pulse_meter #(
        .CLOCK_HZ (48000000),
        .MIN_NS   (255),
        .COUNT_W  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   strobe_cnt = 0;
    int   exp_count = 0;
    bit   exp_seen = 1'b0;
    bit   prev_valid = 1'b0;

    // Model: qualification threshold is ceil(255 ns * 48 MHz) = 13 cycles, counter max 255.
    task automatic push_expect(input int n);
        exp_t e;
        e.width = (n > 255) ? 255 : n;
        e.ts    = (n < 13);
        e.sat   = (n >= 255);
        if (!e.ts) begin
            exp_count = (exp_count + 1) % 256;
            exp_seen  = 1'b1;
        end
        e.cnt  = exp_count;
        e.seen = exp_seen;
        sb_q.push_back(e);
    endtask

    task automatic drive_pulse(input int n);
        @(posedge clk); #1 bus.pulse_in = 1'b1;
        repeat (n) @(posedge clk);
        #1 bus.pulse_in = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        exp_count = 0;
        exp_seen  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: %0d strobes pending, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    // Scoreboard: every strobe is popped against the oldest expectation.
    always @(negedge clk) begin
        if (bus.width_valid) begin
            strobe_cnt++;
            n_cmp++;
            if (prev_valid) begin
                n_bad++;
                $display("FAIL strobe_len: width_valid high 2 cycles, required 1");
            end
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_strobe: width_out=%0d, required no strobe", bus.width_out);
            end else begin
                mon_e = sb_q.pop_front();
                n_cmp += 4;
                if (bus.width_out !== 8'(mon_e.width)) begin
                    n_bad++;
                    $display("FAIL width_out: got %0d, required %0d", bus.width_out, mon_e.width);
                end
                if (bus.too_short !== mon_e.ts || bus.saturated !== mon_e.sat) begin
                    n_bad++;
                    $display("FAIL flags (w=%0d): too_short=%b saturated=%b, required %b %b",
                             mon_e.width, bus.too_short, bus.saturated, mon_e.ts, mon_e.sat);
                end
                if (bus.pulse_count !== 8'(mon_e.cnt)) begin
                    n_bad++;
                    $display("FAIL pulse_count: got %0d, required %0d", bus.pulse_count, mon_e.cnt);
                end
                if (bus.reset_seen !== mon_e.seen) begin
                    n_bad++;
                    $display("FAIL reset_seen: got %b, required %b", bus.reset_seen, mon_e.seen);
                end
            end
        end
        prev_valid = bus.width_valid;
    end

    task automatic test_reset();
        bus.pulse_in    = 1'b0;
        bus.clear_flags = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.width_out, bus.width_valid, bus.too_short, bus.saturated,
             bus.reset_seen, bus.pulse_count} !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_in: outputs w=%0d v=%b ts=%b sat=%b seen=%b cnt=%0d, required all 0",
                     bus.width_out, bus.width_valid, bus.too_short, bus.saturated,
                     bus.reset_seen, bus.pulse_count);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({bus.width_out, bus.width_valid, bus.too_short, bus.saturated,
             bus.reset_seen, bus.pulse_count} !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_after: outputs not 0 after release, required all 0");
        end
    endtask

    task automatic test_qualified();
        push_expect(20); drive_pulse(20); wait_drain("qualified_20");
    endtask

    task automatic test_short();
        push_expect(5);  drive_pulse(5);  wait_drain("short_5");
        push_expect(12); drive_pulse(12); wait_drain("short_12");
        push_expect(13); drive_pulse(13); wait_drain("boundary_13");
    endtask

    task automatic test_saturate();
        push_expect(254); drive_pulse(254); wait_drain("sat_254");
        push_expect(255); drive_pulse(255); wait_drain("sat_255");
        push_expect(300); drive_pulse(300); wait_drain("sat_300");
    endtask

    task automatic test_back_to_back();
        push_expect(14); push_expect(1); push_expect(16);
        drive_pulse(14); drive_pulse(1); drive_pulse(16);
        wait_drain("back_to_back");
    endtask

    task automatic test_high_at_reset();
        int s0;
        @(posedge clk); #1 bus.pulse_in = 1'b1; rst_n = 1'b0;
        exp_count = 0;
        exp_seen  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        s0 = strobe_cnt;
        repeat (40) @(posedge clk);
        #1 bus.pulse_in = 1'b0;
        repeat (2) @(posedge clk);
        push_expect(20); drive_pulse(20); wait_drain("high_at_reset");
        repeat (4) @(negedge clk);
        n_cmp++;
        if (strobe_cnt - s0 != 1) begin
            n_bad++;
            $display("FAIL high_at_reset_strobes: got %0d, required 1", strobe_cnt - s0);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        s0 = strobe_cnt;
        @(posedge clk); #1 bus.pulse_in = 1'b1;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        exp_count = 0;
        exp_seen  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.width_out, bus.width_valid, bus.too_short, bus.saturated,
             bus.reset_seen, bus.pulse_count} !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_mid_clear: outputs w=%0d seen=%b cnt=%0d, required all 0",
                     bus.width_out, bus.reset_seen, bus.pulse_count);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (17) @(posedge clk);
        #1 bus.pulse_in = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (strobe_cnt != s0 || {bus.width_out, bus.too_short, bus.saturated,
                                 bus.reset_seen, bus.pulse_count} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_mid_discard: strobes=%0d w=%0d cnt=%0d, required 0 0 0",
                     strobe_cnt - s0, bus.width_out, bus.pulse_count);
        end
        push_expect(15); drive_pulse(15); wait_drain("after_reset_15");
    endtask

    task automatic test_clear_flags();
        push_expect(20);
        drive_pulse(20);
        @(posedge clk);
        @(posedge clk); #1 bus.clear_flags = 1'b1;
        @(posedge clk); #1 bus.clear_flags = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.width_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_strobe_align: width_valid=%b on 3rd edge after fall, required 1",
                     bus.width_valid);
        end
        wait_drain("clear_coincide");
        @(posedge clk); #1 bus.clear_flags = 1'b1;
        @(posedge clk); #1 bus.clear_flags = 1'b0;
        exp_seen = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.reset_seen !== exp_seen || bus.pulse_count !== 8'(exp_count)) begin
            n_bad++;
            $display("FAIL clear_alone: reset_seen=%b cnt=%0d, required %b %0d",
                     bus.reset_seen, bus.pulse_count, exp_seen, exp_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            push_expect(13);
            drive_pulse(13);
        end
        wait_drain("wrap");
        @(negedge clk);
        n_cmp++;
        if (bus.pulse_count !== 8'd0) begin
            n_bad++;
            $display("FAIL wrap_count: got %0d, required 0", bus.pulse_count);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_qualified();
        test_short();
        test_saturate();
        test_back_to_back();
        test_high_at_reset();
        test_reset_mid();
        test_clear_flags();
        test_wrap();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
